// File: rtl/shared_mem_responder.sv
// Two-port memory responder: round-robin arbitration onto one shared word-addressed RAM,
// with WAIT wait-states between grant and a single-cycle ack carrying registered read data.
module shared_mem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] adr0,
    input  logic [31:0] wd0,
    output logic [31:0] rd0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] adr1,
    input  logic [31:0] wd1,
    output logic [31:0] rd1,
    output logic        ack1,
    output logic        busy,
    output logic        gnt_id
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic             prio;
    logic             win;
    logic             sel_we;
    logic [31:0]      sel_adr;
    logic [31:0]      sel_wd;
    logic [IDX_W-1:0] idx;
    logic [31:0]      mem [DEPTH];

    // Only the word-index bits of the address reach the RAM; the rest are deliberately dropped.
    logic unused_adr;
    assign unused_adr = ^{adr0, adr1};

    // The granted port's inputs are read live, so the access completes with whatever the port presents.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_we  = we0;
        sel_adr = adr0;
        sel_wd  = wd0;
        if (gnt_id) begin
            sel_we  = we1;
            sel_adr = adr1;
            sel_wd  = wd1;
        end
    end

    assign idx = sel_adr[2 +: IDX_W];

    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = prio;
        end else if (req1) begin
            win = 1'b1;
        end

        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = GRANT;
            GRANT:   if (cnt == 4'd0)  state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Read data is captured on entry to ACK so it is already valid during the ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            prio   <= 1'b0;
            gnt_id <= 1'b0;
            rd0    <= 32'd0;
            rd1    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id <= win;
                        prio   <= ~win;
                        cnt    <= WAIT_CNT;
                    end
                end
                GRANT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!sel_we) begin
                        if (gnt_id) rd1 <= mem[idx];
                        else        rd0 <= mem[idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM is intentionally not reset so it maps onto block memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && state == ACK && sel_we) begin
            mem[idx] <= sel_wd;
        end
    end

    // Reset in the ack cycle aborts the access, so it also suppresses the pulse.
    assign ack0 = (state == ACK) && !gnt_id && !reset;
    assign ack1 = (state == ACK) &&  gnt_id && !reset;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder: a word-array reference model predicts every ack
// (port, cycle, read data); an independent monitor pops and compares whenever an ack appears.
module tb_shared_mem_responder;
    localparam int DEPTH  = 64;
    localparam int WAIT   = 2;
    localparam int BUDGET = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] adr0 = '0, wd0 = '0, adr1 = '0, wd1 = '0;
    logic [31:0] rd0, rd1;
    logic        ack0, ack1, busy, gnt_id;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] data;
        longint      cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ack_count = 0;
    longint      cyc = 0;
    logic [31:0] model_mem [DEPTH];
    bit          model_prio = 1'b0;
    logic [31:0] last_rd [2];

    shared_mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .rd0(rd0), .ack0(ack0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .rd1(rd1), .ack1(ack1),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks expected completion", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest prediction.
    initial begin : monitor
        exp_t e;
        bit   prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                ack_count++;
                check("ack_pulse_width", 64'(prev_ack), 64'd0);
                check("ack_exclusive", 64'(ack0 & ack1), 64'd0);
                check("ack_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ack_port", 64'(ack1), 64'(e.port));
                    check("ack_latency", cyc, e.cyc);
                    check("busy_in_ack", 64'(busy), 64'd1);
                    check("gnt_id_in_ack", 64'(gnt_id), 64'(e.port));
                    if (!e.we) last_rd[e.port] = e.data;
                    check("rd0", 64'(rd0), 64'(last_rd[0]));
                    check("rd1", 64'(rd1), 64'(last_rd[1]));
                end
                prev_ack = 1'b1;
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    function automatic int unsigned idx_of(input logic [31:0] adr);
        return (adr / 4) % DEPTH;
    endfunction

    // Reference: accesses are atomic and applied in service order; each grant hands priority to the other port.
    function automatic void model_access(input bit p, input bit we, input logic [31:0] adr,
                                         input logic [31:0] wd, input longint at);
        exp_t        e;
        int unsigned i;
        i      = idx_of(adr);
        e.port = p;
        e.we   = we;
        e.cyc  = at;
        if (we) begin
            model_mem[i] = wd;
            e.data       = wd;
        end else begin
            e.data = model_mem[i];
        end
        sb.push_back(e);
        model_prio = !p;
    endfunction

    function automatic void model_reset();
        model_prio = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
    endfunction

    task automatic set_port(input bit p, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        if (p) begin
            req1 = 1'b1; we1 = we; adr1 = adr; wd1 = wd;
        end else begin
            req0 = 1'b1; we0 = we; adr0 = adr; wd0 = wd;
        end
    endtask

    // Drops each request in its ack cycle; ends on the negedge of the last ack.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((req0 || req1) && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        check({name, "_completed"}, 64'({req0, req1}), 64'd0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic access(input bit p, input bit we, input logic [31:0] adr, input logic [31:0] wd);
        @(negedge clk);
        set_port(p, we, adr, wd);
        model_access(p, we, adr, wd, cyc + 2 + WAIT);
        wait_done("single");
    endtask

    task automatic access_pair(input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                               input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        longint first_at;
        @(negedge clk);
        set_port(1'b0, w0, a0, d0);
        set_port(1'b1, w1, a1, d1);
        first_at = cyc + 2 + WAIT;
        if (!model_prio) begin
            model_access(1'b0, w0, a0, d0, first_at);
            model_access(1'b1, w1, a1, d1, first_at + 3 + WAIT);
        end else begin
            model_access(1'b1, w1, a1, d1, first_at);
            model_access(1'b0, w0, a0, d0, first_at + 3 + WAIT);
        end
        wait_done("pair");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : stimulus
        int n0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (5) @(negedge clk);
        check("reset_ack0", 64'(ack0), 64'd0);
        check("reset_ack1", 64'(ack1), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rd0", 64'(rd0), 64'd0);
        check("reset_rd1", 64'(rd1), 64'd0);
        check("reset_gnt_id", 64'(gnt_id), 64'd0);

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            access(1'($urandom_range(0, 1)), 1'b1, 32'(i * 4) | ($urandom & 32'hFFFF_FF03), $urandom);
        end

        // Both ports from reset: port0 first, then alternation while both keep asking.
        do_reset();
        access_pair(1'b0, 32'h8, 32'h0, 1'b0, 32'hC, 32'h0);
        access_pair(1'b1, 32'h8, 32'hA5A5_0001, 1'b0, 32'h8, 32'h0);
        access_pair(1'b0, 32'h8, 32'h0, 1'b1, 32'h8, 32'h5A5A_0002);

        // Address wrap and ignored byte-offset bits.
        access(1'b0, 1'b1, 32'h100, 32'h5);
        access(1'b0, 1'b0, 32'h0, 32'h0);
        access(1'b1, 1'b0, 32'h103, 32'h0);

        // Reset during GRANT: store is dropped, no ack.
        @(negedge clk);
        set_port(1'b0, 1'b1, 32'h20, 32'h1234);
        repeat (2) @(negedge clk);
        n0    = ack_count;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        check("abort_grant_no_ack", 64'(ack_count), 64'(n0));
        check("abort_grant_idle", 64'(busy), 64'd0);
        access(1'b0, 1'b0, 32'h20, 32'h0);

        // Reset asserted inside the ACK cycle: no pulse, no write.
        @(negedge clk);
        set_port(1'b0, 1'b1, 32'h24, 32'h5678);
        repeat (3) @(negedge clk);
        n0 = ack_count;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("abort_ack_ack0", 64'(ack0), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        req0 = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check("abort_ack_no_ack", 64'(ack_count), 64'(n0));
        access(1'b0, 1'b0, 32'h24, 32'h0);

        // Core1 load alone: rd0 untouched (monitor), gnt_id stays on port 1 afterwards.
        access(1'b1, 1'b0, 32'h44, 32'h0);
        repeat (2) @(negedge clk);
        check("last_gnt_id", 64'(gnt_id), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 2))
                0: access(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                1: access(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                default: access_pair(1'($urandom_range(0, 1)), $urandom & 32'h3F, $urandom,
                                     1'($urandom_range(0, 1)), $urandom & 32'h3F, $urandom);
            endcase
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
